// File: rtl/dram_rr_arbiter.sv
// Round-robin arbiter sharing one DRAM controller port among NCORES cores,
// with bounded bus locking for atomic read-modify-write sequences.
module dram_rr_arbiter #(
  parameter int NCORES   = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic [NCORES-1:0]    req_i,
  input  logic [NCORES-1:0]    we_i,
  input  logic [NCORES-1:0]    lock_i,
  input  logic [NCORES*AW-1:0] addr_i,
  input  logic [NCORES*DW-1:0] wdata_i,
  output logic [NCORES-1:0]    ack_o,
  output logic [DW-1:0]        rdata_o,
  output logic [2:0]           grant_o,
  output logic                 gvalid_o,
  output logic [AW-1:0]        dram_addr,
  output logic [DW-1:0]        dram_wdata,
  output logic                 dram_we,
  output logic                 dram_le,
  input  logic                 dram_busy,
  input  logic [DW-1:0]        dram_odata
);

  // state | meaning
  // IDLE  | arbitrate among requesters (or the locked owner)
  // ISSUE | wait for controller idle, then fire one start pulse
  // GAP   | start pulse visible; controller raises busy next cycle
  // WAIT  | controller busy; capture read data when it drops
  // DONE  | ack pulse to the granted core; update pointer and lock
  typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, DONE} state_t;

  state_t        state;
  logic [2:0]    last;
  logic [3:0]    lock_cnt;
  logic          locked;
  logic          op_we;

  logic [7:0]    req_ext;
  logic [7:0]    lock_ext;
  logic          found;
  logic [2:0]    win;
  logic [3:0]    cand;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;
  logic          we_sel;

  assign req_ext  = 8'(req_i);
  assign lock_ext = 8'(lock_i);

  // A locked owner without a pending request falls back to plain round-robin.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    cand  = 4'd0;
    if (locked && req_ext[grant_o]) begin
      found = 1'b1;
      win   = grant_o;
    end else begin
      for (int i = 1; i <= NCORES; i++) begin
        cand = {1'b0, last} + 4'(i);
        if (cand >= 4'(NCORES)) cand = cand - 4'(NCORES);
        if (!found && req_ext[cand[2:0]]) begin
          found = 1'b1;
          win   = cand[2:0];
        end
      end
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int k = 0; k < NCORES; k++) begin
      if (win == 3'(k)) begin
        addr_sel  = addr_i[k*AW +: AW];
        wdata_sel = wdata_i[k*DW +: DW];
        we_sel    = we_i[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state      <= IDLE;
      last       <= 3'(NCORES-1);
      lock_cnt   <= 4'd0;
      locked     <= 1'b0;
      op_we      <= 1'b0;
      ack_o      <= '0;
      rdata_o    <= '0;
      grant_o    <= 3'd0;
      gvalid_o   <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
      dram_we    <= 1'b0;
      dram_le    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_o    <= win;
            dram_addr  <= addr_sel;
            dram_wdata <= wdata_sel;
            op_we      <= we_sel;
            gvalid_o   <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!dram_busy) begin
            dram_we <= op_we;
            dram_le <= !op_we;
            state   <= GAP;
          end
        end
        GAP: begin
          dram_we <= 1'b0;
          dram_le <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (!dram_busy) begin
            if (!op_we) rdata_o <= dram_odata;
            ack_o <= NCORES'(8'd1 << grant_o);
            state <= DONE;
          end
        end
        DONE: begin
          ack_o    <= '0;
          last     <= grant_o;
          gvalid_o <= 1'b0;
          state    <= IDLE;
          if (lock_ext[grant_o] && (lock_cnt < 4'(MAX_LOCK-1))) begin
            lock_cnt <= lock_cnt + 4'd1;
            locked   <= 1'b1;
          end else begin
            lock_cnt <= 4'd0;
            locked   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Scoreboard bench for dram_rr_arbiter: per-core drivers, a DRAM busy model,
// and a monitor that checks every start pulse and ack against expected order.
module tb_dram_rr_arbiter;
  localparam int NC = 2;

  logic          CLK = 1'b0;
  logic          RST_X = 1'b0;
  logic [NC-1:0] req_i = '0, we_i = '0, lock_i = '0;
  logic [63:0]   addr_i = '0, wdata_i = '0;
  logic [NC-1:0] ack_o;
  logic [31:0]   rdata_o, dram_addr, dram_wdata;
  logic [2:0]    grant_o;
  logic          gvalid_o, dram_we, dram_le;
  logic          dram_busy;
  logic [31:0]   dram_odata = '0;

  logic          mbusy = 1'b0, force_busy = 1'b0, pend = 1'b0;
  int            bcnt = 0, busy_len = 1;
  logic [31:0]   model_odata = '0;
  int            errors = 0, checks = 0;

  assign dram_busy = mbusy | force_busy;

  typedef struct { logic [2:0] g; logic we; logic [31:0] addr, wdata, rdata; } exp_t;
  typedef struct { logic we, lock; logic [31:0] addr, wdata; } pl_t;
  exp_t exp_q[$];
  pl_t  cq0[$], cq1[$];

  dram_rr_arbiter #(.NCORES(NC), .AW(32), .DW(32), .MAX_LOCK(4)) dut (
    .CLK(CLK), .RST_X(RST_X), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .grant_o(grant_o), .gvalid_o(gvalid_o), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_we(dram_we), .dram_le(dram_le),
    .dram_busy(dram_busy), .dram_odata(dram_odata));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // DRAM controller: busy rises the cycle after a start pulse, lasts busy_len cycles.
  always @(negedge CLK) begin
    if (!RST_X) begin
      mbusy = 1'b0; bcnt = 0; pend = 1'b0;
    end else begin
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin mbusy = 1'b0; dram_odata = model_odata; end
      end
      if (pend) begin mbusy = 1'b1; bcnt = busy_len; pend = 1'b0; end
      if (dram_le || dram_we) pend = 1'b1;
    end
  end

  // Core requesters: on ack, retire the current payload and present the next.
  always @(negedge CLK) begin
    if (ack_o[0] && cq0.size() > 0) void'(cq0.pop_front());
    if (ack_o[1] && cq1.size() > 0) void'(cq1.pop_front());
    if (cq0.size() > 0) begin
      req_i[0] = 1'b1; we_i[0] = cq0[0].we; lock_i[0] = cq0[0].lock;
      addr_i[31:0] = cq0[0].addr; wdata_i[31:0] = cq0[0].wdata;
    end else begin
      req_i[0] = 1'b0; lock_i[0] = 1'b0;
    end
    if (cq1.size() > 0) begin
      req_i[1] = 1'b1; we_i[1] = cq1[0].we; lock_i[1] = cq1[0].lock;
      addr_i[63:32] = cq1[0].addr; wdata_i[63:32] = cq1[0].wdata;
    end else begin
      req_i[1] = 1'b0; lock_i[1] = 1'b0;
    end
  end

  // Monitor
  always @(negedge CLK) begin
    if (RST_X) begin
      if (dram_le || dram_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 64'(1), 64'(0));
        end else begin
          chk("start_grant", 64'(grant_o), 64'(exp_q[0].g));
          chk("start_we", 64'(dram_we), 64'(exp_q[0].we));
          chk("start_le", 64'(dram_le), 64'(!exp_q[0].we));
          chk("start_addr", 64'(dram_addr), 64'(exp_q[0].addr));
          if (exp_q[0].we) chk("start_wdata", 64'(dram_wdata), 64'(exp_q[0].wdata));
        end
      end
      if (ack_o != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'(ack_o), 64'(0));
        end else begin
          logic [1:0] ea;
          ea = 2'b01 << exp_q[0].g;
          chk("ack_onehot", 64'(ack_o), 64'(ea));
          chk("ack_rdata", 64'(rdata_o), 64'(exp_q[0].rdata));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic load(input int c, input logic we, input logic lk,
                      input logic [31:0] a, input logic [31:0] d);
    pl_t p;
    p.we = we; p.lock = lk; p.addr = a; p.wdata = d;
    if (c == 0) cq0.push_back(p); else cq1.push_back(p);
  endtask

  task automatic expect_tr(input logic [2:0] g, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] r);
    exp_t e;
    e.g = g; e.we = we; e.addr = a; e.wdata = d; e.rdata = r;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_X = 1'b0;
    exp_q.delete(); cq0.delete(); cq1.delete();
    force_busy = 1'b0;
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cq0.size() != 0 || cq1.size() != 0) && n < 600) begin
      @(negedge CLK); n++;
    end
    chk({nm, "_drain_timeout"}, 64'(exp_q.size() + cq0.size() + cq1.size()), 64'(0));
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ack"}, 64'(ack_o), 64'(0));
    chk({nm, "_rdata"}, 64'(rdata_o), 64'(0));
    chk({nm, "_grant"}, 64'(grant_o), 64'(0));
    chk({nm, "_gvalid"}, 64'(gvalid_o), 64'(0));
    chk({nm, "_addr"}, 64'(dram_addr), 64'(0));
    chk({nm, "_wdata"}, 64'(dram_wdata), 64'(0));
    chk({nm, "_we"}, 64'(dram_we), 64'(0));
    chk({nm, "_le"}, 64'(dram_le), 64'(0));
  endtask

  initial begin
    int n;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;

    // Single read
    busy_len = 3; model_odata = 32'hDEADBEEF;
    expect_tr(3'd0, 1'b0, 32'h80001000, 32'h0, 32'hDEADBEEF);
    load(0, 1'b0, 1'b0, 32'h80001000, 32'h0);
    n = 0;
    do begin @(negedge CLK); n++; end while (ack_o == '0 && n < 100);
    chk("read_ack_seen", 64'(ack_o), 64'(2'b01));
    chk("read_gvalid_in_ack", 64'(gvalid_o), 64'(1));
    @(negedge CLK);
    chk("read_gvalid_after_ack", 64'(gvalid_o), 64'(0));
    drain("read");

    // Contention: strict alternation starting at core0 after reset
    do_reset();
    busy_len = 1;
    for (int i = 0; i < 4; i++) begin
      load(0, 1'b1, 1'b0, 32'h100 + i, 32'hA000 + i);
      load(1, 1'b1, 1'b0, 32'h200 + i, 32'hB000 + i);
      expect_tr(3'd0, 1'b1, 32'h100 + i, 32'hA000 + i, 32'h0);
      expect_tr(3'd1, 1'b1, 32'h200 + i, 32'hB000 + i, 32'h0);
    end
    drain("contention");

    // Lock: core1 chains 4, core0 breaks in, core1 resumes
    do_reset();
    busy_len = 2;
    for (int i = 0; i < 6; i++) load(1, 1'b1, 1'b1, 32'h300 + i, 32'hC000 + i);
    for (int i = 0; i < 4; i++) expect_tr(3'd1, 1'b1, 32'h300 + i, 32'hC000 + i, 32'h0);
    expect_tr(3'd0, 1'b1, 32'h400, 32'hD000, 32'h0);
    expect_tr(3'd1, 1'b1, 32'h304, 32'hC004, 32'h0);
    expect_tr(3'd1, 1'b1, 32'h305, 32'hC005, 32'h0);
    expect_tr(3'd0, 1'b1, 32'h401, 32'hD001, 32'h0);
    repeat (2) @(negedge CLK);
    load(0, 1'b1, 1'b0, 32'h400, 32'hD000);
    load(0, 1'b1, 1'b0, 32'h401, 32'hD001);
    drain("lock");

    // Busy held at issue
    do_reset();
    busy_len = 1; force_busy = 1'b1;
    expect_tr(3'd0, 1'b1, 32'h40, 32'h12345678, 32'h0);
    load(0, 1'b1, 1'b0, 32'h40, 32'h12345678);
    n = 0;
    do begin @(negedge CLK); n++; end while (!gvalid_o && n < 50);
    chk("issue_entered", 64'(gvalid_o), 64'(1));
    for (int i = 0; i < 5; i++) begin
      chk("no_pulse_while_busy", 64'({dram_we, dram_le}), 64'(0));
      @(negedge CLK);
    end
    force_busy = 1'b0;
    drain("busy_issue");

    // Reset during WAIT
    do_reset();
    busy_len = 10;
    expect_tr(3'd0, 1'b0, 32'h500, 32'h0, 32'h0);
    load(0, 1'b0, 1'b0, 32'h500, 32'h0);
    n = 0;
    do begin @(negedge CLK); n++; end while (!mbusy && n < 50);
    chk("wait_reached", 64'(mbusy), 64'(1));
    RST_X = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete(); cq0.delete(); cq1.delete();
    repeat (3) @(negedge CLK);
    chk("midreset_no_ack", 64'(ack_o), 64'(0));
    RST_X = 1'b1;
    busy_len = 1; model_odata = 32'hC0FFEE11;
    expect_tr(3'd1, 1'b0, 32'h600, 32'h0, 32'hC0FFEE11);
    load(1, 1'b0, 1'b0, 32'h600, 32'h0);
    drain("after_reset");

    // Write leaves rdata untouched
    do_reset();
    busy_len = 2; model_odata = 32'hA5A5A5A5;
    expect_tr(3'd0, 1'b0, 32'h700, 32'h0, 32'hA5A5A5A5);
    expect_tr(3'd0, 1'b1, 32'h704, 32'h55AA55AA, 32'hA5A5A5A5);
    load(0, 1'b0, 1'b0, 32'h700, 32'h0);
    load(0, 1'b1, 1'b0, 32'h704, 32'h55AA55AA);
    drain("write_rdata");
    chk("rdata_hold", 64'(rdata_o), 64'(32'hA5A5A5A5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
